// File: rtl/mux_pkg.sv
// Shared helpers for the round-robin multiplexer: index-width derivation
// and modular wrap of a rotating scan position.
package mux_pkg;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // (base + off) mod n, valid for base < n and off < n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return ((base + off) >= n) ? (base + off - n) : (base + off);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter. Scans req starting at ptr and
// wrapping around; the first requester found wins. No state is kept here.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    int cand_s;

    // Walk the channels in rotated order and latch the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand_s  = 0;
        for (int i = 0; i < N_CH; i++) begin
            cand_s      = wrap_idx(int'(ptr), i, N_CH);
            gnt[cand_s] = en && !any && req[cand_s];
            gnt_idx     = gnt[cand_s] ? CH_W'(cand_s) : gnt_idx;
            any         = any | gnt[cand_s];
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel round-robin multiplexer with valid/ready on every channel,
// optional per-channel bit inversion and a single registered output stage.
// The output register refills in the same cycle it drains, so a steady
// downstream accept gives one word per cycle.
module rr_mux_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int CH_W  = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       inv_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch
);

    logic              load_s;
    logic              arb_en_s;
    logic [N_CH-1:0]   gnt_s;
    logic [CH_W-1:0]   gnt_idx_s;
    logic              any_s;
    logic [WIDTH-1:0]  sel_word_s;
    logic [CH_W-1:0]   ptr_nxt_s;
    logic [CH_W-1:0]   ptr_r;

    // The output slot can take a word when empty or being drained; grants are
    // suppressed while reset is held so no channel believes it was accepted.
    always_comb begin
        load_s   = !out_valid || out_ready;
        arb_en_s = load_s && !rst;
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_r),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // Ready is exactly the one-hot grant; it never looks at data.
    always_comb begin
        in_ready = gnt_s;
    end

    // Pick the granted word, apply its inversion, and compute the pointer
    // that places the granted channel last in the next scan.
    always_comb begin
        sel_word_s = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH]
                     ^ {WIDTH{inv_mask[gnt_idx_s]}};
        ptr_nxt_s  = (gnt_idx_s == CH_W'(N_CH - 1)) ? '0 : (gnt_idx_s + CH_W'(1));
    end

    // Output stage and round-robin pointer: load on grant, empty on an
    // unreplaced drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_r     <= '0;
        end else if (any_s) begin
            out_valid <= 1'b1;
            out_data  <= sel_word_s;
            out_ch    <= gnt_idx_s;
            ptr_r     <= ptr_nxt_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (4 channels, 8 bits) with a transfer
// scoreboard watching every accepted and delivered word.
module tb_rr_mux_arbiter;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int CH_W  = 2;

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       inv_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [CH_W-1:0]  c;
    } item_t;

    item_t sb_q[$];

    rr_mux_arbiter #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .inv_mask  (inv_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    // Scoreboard: delivered words must match accepted words in order.
    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(it.d));
                    chk("sb_ch",   32'(out_ch),   32'(it.c));
                end
            end
            for (int k = 0; k < N_CH; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    it.d = in_data[k*WIDTH +: WIDTH] ^ {WIDTH{inv_mask[k]}};
                    it.c = CH_W'(k);
                    sb_q.push_back(it);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        inv_mask  = 4'h0;
        out_ready = 1'b0;

        // 1: reset state with all channels requesting
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("first_grant", 32'(in_ready), 32'h1);

        // 2: round-robin over all channels, one word per cycle
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("rr", CH_W'(i % 4), 8'h10 + 8'(i % 4));
        end

        // 3: backpressure holds the output and blocks grants
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_hold", 2'd3, 8'h13);
            chk("bp_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(in_ready), 32'h1);
        tick();
        chk_out("bp_next", 2'd0, 8'h10);

        // 4: idle channels are skipped
        in_valid = 4'b1010;
        #1;
        chk("skip_grant", 32'(in_ready), 32'b0010);
        tick(); chk_out("skip_a", 2'd1, 8'h11);
        tick(); chk_out("skip_b", 2'd3, 8'h13);
        tick(); chk_out("skip_c", 2'd1, 8'h11);
        tick(); chk_out("skip_d", 2'd3, 8'h13);
        in_valid = 4'b0001;
        #1;
        chk("lone_ch0_grant", 32'(in_ready), 32'b0001);
        tick(); chk_out("lone_ch0", 2'd0, 8'h10);

        // 5: inversion applies only to masked channel
        in_valid = 4'b0100;
        in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        inv_mask = 4'b0100;
        #1;
        chk("inv_grant", 32'(in_ready), 32'b0100);
        tick(); chk_out("inv_ch2", 2'd2, 8'h5A);
        in_valid = 4'b0010;
        tick(); chk_out("noinv_ch1", 2'd1, 8'h11);
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_data",  32'(out_data),  32'h11);
        chk("drain_ch",    32'(out_ch),    32'd1);

        // 6: reset while holding a word
        in_valid  = 4'hF;
        out_ready = 1'b0;
        tick(); chk_out("pre_rst", 2'd2, 8'h5A);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_ch",    32'(out_ch),    32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(in_ready), 32'h1);
        tick(); chk_out("post_rst", 2'd0, 8'h10);
        in_valid = 4'h0;
        tick();
        chk("final_empty", 32'(out_valid), 32'd0);
        #5;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
